// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: PC generator, valid/ready request port to an in-order
// variable-latency instruction memory, and a DEPTH-entry prefetch queue toward decode.
module dlx_fetch_unit #(
   parameter int unsigned        PC_SIZE  = 32,
   parameter int unsigned        IR_SIZE  = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [PC_SIZE-1:0] RESET_PC = '0,
   parameter int unsigned        PC_INC   = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_SIZE-1:0] imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [IR_SIZE-1:0] imem_rsp_data,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [IR_SIZE-1:0] ir,
   output logic [PC_SIZE-1:0] ir_pc,
   output logic [PC_SIZE-1:0] npc,
   input  logic               redirect_en,
   input  logic [PC_SIZE-1:0] redirect_pc,
   output logic               busy
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~(PC_SIZE'(PC_INC - 1));
   localparam logic [PC_SIZE-1:0] PC_STEP    = PC_SIZE'(PC_INC);

   typedef logic [PW-1:0] ptr_t;

   logic [PC_SIZE-1:0] pc_q, pc_d;
   ptr_t               alloc_q, alloc_d;
   ptr_t               fill_q, fill_d;
   ptr_t               rd_q, rd_d;
   ptr_t               drop_q, drop_d;
   logic [DEPTH-1:0]   filled_q, filled_d;
   logic [PC_SIZE-1:0] pc_mem_q    [DEPTH];
   logic [IR_SIZE-1:0] instr_mem_q [DEPTH];

   logic [IW-1:0] alloc_idx, fill_idx, rd_idx;
   ptr_t          unfilled, in_use;
   logic [PW:0]   occupancy;
   logic [PW:0]   drop_sum;
   logic          req_fire, rsp_take, rsp_drop, deq, rsp_expected;

   assign alloc_idx = alloc_q[IW-1:0];
   assign fill_idx  = fill_q[IW-1:0];
   assign rd_idx    = rd_q[IW-1:0];

   assign unfilled  = alloc_q - fill_q;
   assign in_use    = alloc_q - rd_q;
   assign occupancy = {1'b0, in_use} + {1'b0, drop_q};

   assign imem_req_valid = !rst && !redirect_en && (occupancy < (PW+1)'(DEPTH));
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign ir_valid = filled_q[rd_idx];
   assign ir       = instr_mem_q[rd_idx];
   assign ir_pc    = pc_mem_q[rd_idx];
   assign npc      = ir_pc + PC_STEP;
   assign deq      = ir_valid && ir_ready;

   // Responses are in order, so stale responses from before a redirect always drain first.
   assign rsp_expected = (drop_q != '0) || (unfilled != '0);
   assign rsp_drop     = imem_rsp_valid && (drop_q != '0);
   assign rsp_take     = imem_rsp_valid && !redirect_en && (drop_q == '0) && (unfilled != '0);

   assign busy = rsp_expected;

   assign drop_sum = {1'b0, drop_q} + {1'b0, unfilled}
                     - (PW+1)'(imem_rsp_valid && rsp_expected);

   always_comb begin
      pc_d     = pc_q;
      alloc_d  = alloc_q;
      fill_d   = fill_q;
      rd_d     = rd_q;
      drop_d   = drop_q;
      filled_d = filled_q;
      if (redirect_en) begin
         pc_d     = redirect_pc & ALIGN_MASK;
         alloc_d  = '0;
         fill_d   = '0;
         rd_d     = '0;
         filled_d = '0;
         drop_d   = drop_sum[PW-1:0];
      end else begin
         if (req_fire) begin
            pc_d    = pc_q + PC_STEP;
            alloc_d = alloc_q + ptr_t'(1);
         end
         if (rsp_drop) begin
            drop_d = drop_q - ptr_t'(1);
         end else if (rsp_take) begin
            filled_d[fill_idx] = 1'b1;
            fill_d             = fill_q + ptr_t'(1);
         end
         if (deq) begin
            filled_d[rd_idx] = 1'b0;
            rd_d             = rd_q + ptr_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         alloc_q  <= '0;
         fill_q   <= '0;
         rd_q     <= '0;
         drop_q   <= '0;
         filled_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         pc_q     <= pc_d;
         alloc_q  <= alloc_d;
         fill_q   <= fill_d;
         rd_q     <= rd_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
         if (req_fire) pc_mem_q[alloc_idx] <= pc_q;
         if (rsp_take) instr_mem_q[fill_idx] <= imem_rsp_data;
      end
   end

`ifndef SYNTHESIS
   // A response with nothing outstanding is a memory protocol error; the RTL ignores it.
   a_rsp_outstanding : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> rsp_expected);
`endif

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Self-checking bench for dlx_fetch_unit: in-order variable-latency memory model,
// queue-based reference model, table of redirect vectors, directed corner cases, random run.
module tb_dlx_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic [31:0] npc;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        busy;

   always #5 clk = ~clk;

   dlx_fetch_unit #(
      .PC_SIZE(32), .IR_SIZE(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_INC(4)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .npc(npc),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; bit live; } inf_t;
   typedef struct { logic [31:0] pc; logic [31:0] ir; logic [31:0] npc; } dlv_t;
   typedef struct { logic [31:0] rpc; logic [31:0] pc0; logic [31:0] pc1; logic [31:0] pc2; logic [31:0] npc1; } vec_t;

   mreq_t       mem_q[$];
   inf_t        m_infl[$];
   logic [31:0] m_ready[$];
   logic [31:0] m_pc;
   dlv_t        deliv[$];
   logic [31:0] acc_addr[$];
   int          cyc, last_due, lat_min, lat_max;
   int          checks, failures;
   vec_t        tbl[5];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare against the model, advance model and memory, then cross the edge.
   task automatic step();
      bit   exp_rv, dut_acc;
      int   occ, d;
      inf_t e;
      #1;
      occ    = m_ready.size() + m_infl.size();
      exp_rv = !rst && !redirect_en && (occ < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("imem_addr", imem_addr, m_pc);
      chk("ir_valid", ir_valid, m_ready.size() > 0);
      if (m_ready.size() > 0) begin
         chk("ir_pc", ir_pc, m_ready[0]);
         chk("ir", ir, memfn(m_ready[0]));
         chk("npc", npc, m_ready[0] + 32'd4);
      end
      chk("busy", busy, m_infl.size() > 0);

      if (ir_valid && ir_ready) deliv.push_back('{ir_pc, ir, npc});
      dut_acc = imem_req_valid && imem_req_ready;
      if (dut_acc) acc_addr.push_back(imem_addr);

      if (rst) begin
         mem_q.delete();
         last_due = 0;
      end else begin
         if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
         if (dut_acc) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d < last_due) d = last_due;
            last_due = d;
            mem_q.push_back('{imem_addr, d});
         end
      end

      if (rst) begin
         m_infl.delete();
         m_ready.delete();
         m_pc = RESET_PC;
      end else begin
         if (m_ready.size() > 0 && ir_ready) void'(m_ready.pop_front());
         if (imem_rsp_valid && m_infl.size() > 0) begin
            e = m_infl.pop_front();
            if (e.live && !redirect_en) m_ready.push_back(e.pc);
         end
         if (redirect_en) begin
            foreach (m_infl[i]) m_infl[i].live = 1'b0;
            m_ready.delete();
            m_pc = redirect_pc & ~32'h3;
         end else if (exp_rv && imem_req_ready) begin
            m_infl.push_back('{m_pc, 1'b1});
            m_pc = m_pc + 32'd4;
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memfn(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic wait_deliv(input int n, input int budget);
      int b;
      b = 0;
      while (deliv.size() < n && b < budget) begin
         step();
         b++;
      end
      chk("wait_deliv_timeout", deliv.size() >= n, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int          d0, n_before, b;
      logic [31:0] p;
      bit          found;

      tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_0108};
      tbl[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_0108};
      tbl[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
      tbl[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
      tbl[4] = '{32'h7FFF_FFFD, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};

      checks = 0; failures = 0; cyc = 0; last_due = 0;
      lat_min = 1; lat_max = 1;
      rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
      ir_ready = 1'b1; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      m_pc = RESET_PC;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      step();
      chk("rst_ir_valid", ir_valid, 1'b0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ir_pc", ir_pc, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_addr", imem_addr, RESET_PC);

      // Initial latency and zero-bubble streaming
      rst = 1'b0;
      deliv.delete();
      step();
      chk("lat_c1_ir_valid", ir_valid, 1'b0);
      step();
      chk("lat_c2_ir_valid", ir_valid, 1'b1);
      chk("lat_first_pc", ir_pc, 32'h0);
      chk("lat_first_npc", npc, 32'h4);
      repeat (6) step();
      chk("stream_count", deliv.size(), 6);
      for (int i = 0; i < 6; i++)
         if (deliv.size() > i) chk("stream_pc", deliv[i].pc, 32'(4 * i));

      // Stall with decode not ready: queue fills to DEPTH, then drains in order
      ir_ready = 1'b0;
      do_reset();
      acc_addr.delete(); deliv.delete();
      repeat (8) step();
      chk("full_accepts", acc_addr.size(), DEPTH);
      chk("full_req_valid", imem_req_valid, 1'b0);
      chk("full_head_pc", ir_pc, 32'h0);
      chk("full_head_valid", ir_valid, 1'b1);
      ir_ready = 1'b1;
      wait_deliv(5, 20);
      for (int i = 0; i < 5; i++) chk("drain_pc", deliv[i].pc, 32'(4 * i));
      chk("refetch_addr", acc_addr[4], 32'h10);

      // 3-cycle memory, two outstanding, then redirect discards both
      lat_min = 3; lat_max = 3;
      do_reset();
      deliv.delete();
      step(); step();
      imem_req_ready = 1'b0;
      redirect_en = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_en = 1'b0;
      chk("redir_busy", busy, 1'b1);
      chk("redir_ir_valid", ir_valid, 1'b0);
      imem_req_ready = 1'b1;
      wait_deliv(1, 30);
      chk("redir_first_pc", deliv[0].pc, 32'h100);
      chk("redir_first_ir", deliv[0].ir, memfn(32'h100));

      // Redirect coinciding with a response and a decode handshake
      lat_min = 2; lat_max = 2;
      do_reset();
      repeat (5) step();
      found = 1'b0; b = 0;
      while (!found && b < 12) begin
         if (imem_rsp_valid && ir_valid) found = 1'b1;
         else begin step(); b++; end
      end
      chk("coincide_found", found, 1'b1);
      n_before = deliv.size();
      redirect_en = 1'b1; redirect_pc = 32'h103; imem_req_ready = 1'b0;
      step();
      redirect_en = 1'b0;
      chk("coincide_hs", deliv.size(), n_before + 1);
      b = 0;
      while (mem_q.size() > 0 && b < 12) begin step(); b++; end
      chk("coincide_drained_busy", busy, 1'b0);
      chk("coincide_drained_valid", ir_valid, 1'b0);
      imem_req_ready = 1'b1;
      d0 = deliv.size();
      wait_deliv(d0 + 1, 20);
      chk("coincide_pc", deliv[d0].pc, 32'h100);
      chk("coincide_npc", deliv[d0].npc, 32'h104);

      // Table: redirect targets, alignment and PC wrap
      lat_min = 1; lat_max = 1;
      ir_ready = 1'b1; imem_req_ready = 1'b1;
      foreach (tbl[k]) begin
         redirect_en = 1'b1; redirect_pc = tbl[k].rpc;
         step();
         redirect_en = 1'b0;
         chk("tbl_addr", imem_addr, tbl[k].pc0);
         d0 = deliv.size();
         wait_deliv(d0 + 3, 30);
         chk("tbl_pc0", deliv[d0].pc, tbl[k].pc0);
         chk("tbl_pc1", deliv[d0 + 1].pc, tbl[k].pc1);
         chk("tbl_pc2", deliv[d0 + 2].pc, tbl[k].pc2);
         chk("tbl_npc1", deliv[d0 + 1].npc, tbl[k].npc1);
      end

      // Reset mid-stream with two requests outstanding
      lat_min = 3; lat_max = 3;
      do_reset();
      step(); step();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      step();
      chk("midrst_ir_valid", ir_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_addr", imem_addr, RESET_PC);
      rst = 1'b0; imem_req_ready = 1'b1;
      lat_min = 1; lat_max = 1;
      d0 = deliv.size();
      wait_deliv(d0 + 2, 20);
      chk("midrst_pc0", deliv[d0].pc, RESET_PC);
      chk("midrst_pc1", deliv[d0 + 1].pc, RESET_PC + 32'd4);

      // Randomised traffic against the model
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         ir_ready       = ($urandom_range(9, 0) < 7);
         imem_req_ready = ($urandom_range(9, 0) < 7);
         redirect_en    = ($urandom_range(39, 0) == 0);
         p              = $urandom;
         redirect_pc    = p;
         rst            = ($urandom_range(399, 0) == 0);
         step();
      end
      rst = 1'b0; redirect_en = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
